// File: rtl/desc_fifo_if.sv
// ---------------------------------------------------------------------------
// desc_fifo_if -- push/pop/status bundle for desc_fifo.
//   master : drives wr_en, last_addr_in, data_size_in, rd_en, clr_err;
//            observes head entry, status flags, level, high_water, errors.
//   slave  : the FIFO side (opposite directions).
// ---------------------------------------------------------------------------
interface desc_fifo_if #(
    parameter int ADDR_W = 8,
    parameter int SIZE_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [ADDR_W-1:0] last_addr_in;
    logic [SIZE_W-1:0] data_size_in;
    logic              rd_en;
    logic              clr_err;
    logic [ADDR_W-1:0] last_addr_out;
    logic [SIZE_W-1:0] data_size_out;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  high_water;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, last_addr_in, data_size_in, rd_en, clr_err,
        input  last_addr_out, data_size_out, empty, full, almost_full,
               almost_empty, level, high_water, overflow, underflow
    );

    modport slave (
        input  wr_en, last_addr_in, data_size_in, rd_en, clr_err,
        output last_addr_out, data_size_out, empty, full, almost_full,
               almost_empty, level, high_water, overflow, underflow
    );
endinterface

// File: rtl/desc_fifo.sv
// ---------------------------------------------------------------------------
// desc_fifo -- first-word-fall-through descriptor FIFO ({addr, size} entries)
// with registered level, threshold flags, peak-level tracking and sticky
// overflow/underflow.
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset (pointers, level, peak, errors)
//   bus   : desc_fifo_if.slave -- push/pop requests, clr_err, head entry,
//           empty/full/almost_full/almost_empty, level, high_water,
//           overflow, underflow
// ---------------------------------------------------------------------------
module desc_fifo #(
    parameter int ADDR_W     = 8,
    parameter int SIZE_W     = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    desc_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
    } desc_t;

    // Storage carries no reset; it is only visible while non-empty.
    desc_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, level, high_water;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt, hw_base, hw_nxt;
    logic             overflow, underflow;
    logic             empty, full, push_ok, pop_ok;
    desc_t            head;

    // Status comes straight from the registered level.
    assign empty = (level == '0);
    assign full  = (level == PTR_W'(DEPTH));

    assign push_ok = bus.wr_en & ~full;
    assign pop_ok  = bus.rd_en & ~empty;

    // Pointers carry a wrap bit, so the modulo-2*DEPTH difference is the
    // true occupancy even when both sit on the same storage index.
    assign wr_ptr_nxt = wr_ptr + PTR_W'(push_ok);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(pop_ok);
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    // clr_err re-bases the peak at the present level; a higher next level
    // still wins so a simultaneous rise is not lost.
    assign hw_base = bus.clr_err ? level : high_water;
    assign hw_nxt  = (level_nxt > hw_base) ? level_nxt : hw_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            high_water <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            level      <= level_nxt;
            high_water <= hw_nxt;
            // Set terms take priority over clr_err.
            overflow   <= (bus.wr_en & full)  | (overflow  & ~bus.clr_err);
            underflow  <= (bus.rd_en & empty) | (underflow & ~bus.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && rst_n)
            mem[wr_ptr[IDX_W-1:0]] <= '{addr: bus.last_addr_in, size: bus.data_size_in};
    end

    // Zero-latency head; stale storage is masked while empty.
    assign head              = mem[rd_ptr[IDX_W-1:0]];
    assign bus.last_addr_out = empty ? '0 : head.addr;
    assign bus.data_size_out = empty ? '0 : head.size;

    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (level >= PTR_W'(AFULL_THR));
    assign bus.almost_empty = (level <= PTR_W'(AEMPTY_THR));
    assign bus.level        = level;
    assign bus.high_water   = high_water;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_desc_fifo.sv
module tb_desc_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 8;
    localparam int SW    = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    desc_fifo_if #(.ADDR_W(AW), .SIZE_W(SW), .DEPTH(DEPTH)) bus ();

    desc_fifo #(.ADDR_W(AW), .SIZE_W(SW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int a;
        int s;
    } ent_t;

    // Reference model: a queue of descriptors plus peak and error flags.
    ent_t mq[$];
    ent_t exp_q[$];
    int   m_ovf = 0, m_udf = 0, m_hw = 0;
    int   nchk = 0, nerr = 0;
    ent_t mon_e;

    task automatic chk(string nm, int act, int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: whenever the DUT presents a head and a pop is requested,
    // the popped entry must match the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL pop_unexpected: got addr %0d expected no pop", bus.last_addr_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_addr", int'(bus.last_addr_out), mon_e.a);
                chk("pop_size", int'(bus.data_size_out), mon_e.s);
            end
        end
    end

    task automatic check_state();
        int lv;
        lv = mq.size();
        chk("level", int'(bus.level), lv);
        chk("empty", int'(bus.empty), int'(lv == 0));
        chk("full", int'(bus.full), int'(lv == DEPTH));
        chk("almost_full", int'(bus.almost_full), int'(lv >= AF));
        chk("almost_empty", int'(bus.almost_empty), int'(lv <= AE));
        chk("overflow", int'(bus.overflow), m_ovf);
        chk("underflow", int'(bus.underflow), m_udf);
        chk("high_water", int'(bus.high_water), m_hw);
        chk("head_addr", int'(bus.last_addr_out), (lv == 0) ? 0 : mq[0].a);
        chk("head_size", int'(bus.data_size_out), (lv == 0) ? 0 : mq[0].s);
    endtask

    // One clock of stimulus; called at posedge+2, returns at next posedge+2.
    task automatic cycle(bit wr, int a, int s, bit rd, bit clr);
        int lv0, base;
        bit fullm, emptym;
        bus.wr_en        = wr;
        bus.last_addr_in = AW'(a);
        bus.data_size_in = SW'(s);
        bus.rd_en        = rd;
        bus.clr_err      = clr;
        lv0    = mq.size();
        fullm  = (lv0 == DEPTH);
        emptym = (lv0 == 0);
        if (rd && !emptym) exp_q.push_back(mq.pop_front());
        if (wr && !fullm) mq.push_back('{a & 255, s & 255});
        base  = clr ? lv0 : m_hw;
        m_hw  = (mq.size() > base) ? mq.size() : base;
        m_ovf = int'((wr && fullm) || (m_ovf != 0 && !clr));
        m_udf = int'((rd && emptym) || (m_udf != 0 && !clr));
        @(posedge clk);
        #1;
        check_state();
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.clr_err = 1'b0;
        bus.last_addr_in = '0; bus.data_size_in = '0;
        // Requests during reset must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check_state();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        idle();

        // Fill: addr=i, size=2i, then one push too many.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 2 * i, 1'b0, 1'b0);
        cycle(1'b1, 99, 99, 1'b0, 1'b0);
        chk("fill_overflow", int'(bus.overflow), 1);
        chk("fill_level", int'(bus.level), DEPTH);

        // Drain in order, then one pop too many.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        chk("drain_underflow", int'(bus.underflow), 1);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Wrap-around at level 5 with random descriptors.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1'b0);
        chk("wrap_level", int'(bus.level), 5);
        while (mq.size() > 0) cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Push+pop on empty, then on full.
        cycle(1'b1, 7, 8, 1'b1, 1'b0);
        chk("pp_empty_level", int'(bus.level), 1);
        chk("pp_empty_udf", int'(bus.underflow), 1);
        while (mq.size() < DEPTH) cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
        cycle(1'b1, 1, 1, 1'b1, 1'b0);
        chk("pp_full_level", int'(bus.level), DEPTH - 1);
        chk("pp_full_ovf", int'(bus.overflow), 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 99) < 55), $urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5));

        // Error clearing: drain, underflow, clear, push 10, pop 4, clear.
        while (mq.size() > 0) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 100 + i, i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        chk("hw_peak", int'(bus.high_water), 10);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("hw_cleared", int'(bus.high_water), 6);
        chk("udf_cleared", int'(bus.underflow), 0);
        chk("ovf_cleared", int'(bus.overflow), 0);

        // Reset mid-operation at level 7, no clock edge needed.
        while (mq.size() > 0) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 200 + i, 3 * i, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);  // underflow not set; set it via empty? keep level 6 -> refill
        cycle(1'b1, 50, 60, 1'b0, 1'b0);
        chk("pre_reset_level", int'(bus.level), 7);
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 0; m_udf = 0; m_hw = 0;
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_addr", int'(bus.last_addr_out), 0);
        chk("rst_size", int'(bus.data_size_out), 0);
        chk("rst_hw", int'(bus.high_water), 0);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        check_state();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) cycle(1'b1, 30 + i, 40 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/desc_fifo.md
DESC_FIFO -- requirements
Module: desc_fifo

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of the last-address field.
REQ-002 SHALL have parameter SIZE_W, default 8: width of the data-size field.
REQ-003 SHALL have parameter DEPTH, default 16: entry count; legal values are powers of two, 2..256.
REQ-004 SHALL have parameter AFULL_THR, default DEPTH-2: almost_full threshold, legal range 1..DEPTH.
REQ-005 SHALL have parameter AEMPTY_THR, default 2: almost_empty threshold, legal range 0..DEPTH-1.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic rises on its posedge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port wr_en, input, 1: push request.
REQ-009 SHALL have port last_addr_in, input, ADDR_W: descriptor address to push.
REQ-010 SHALL have port data_size_in, input, SIZE_W: descriptor size to push.
REQ-011 SHALL have port rd_en, input, 1: pop request.
REQ-012 SHALL have port clr_err, input, 1: clears overflow, underflow and high_water.
REQ-013 SHALL have port last_addr_out, output, ADDR_W: head-entry address.
REQ-014 SHALL have port data_size_out, output, SIZE_W: head-entry size.
REQ-015 SHALL have ports empty, full, almost_full and almost_empty, each output, 1: status flags.
REQ-016 SHALL have port level, output, $clog2(DEPTH)+1: current entry count.
REQ-017 SHALL have port high_water, output, $clog2(DEPTH)+1: peak level since reset or the last clear.
REQ-018 SHALL have ports overflow and underflow, each output, 1: sticky error flags.

Function
REQ-019 Read/write pointers SHALL be $clog2(DEPTH)+1 bits wide; the low bits index storage, the MSB is the wrap bit, and increments wrap naturally modulo 2*DEPTH.
REQ-020 level SHALL equal write_ptr minus read_ptr, computed modulo 2*DEPTH, and SHALL be registered.
REQ-021 A push SHALL be accepted iff wr_en=1 and full=0, where full is the value before the clock edge.
REQ-022 A pop SHALL be accepted iff rd_en=1 and empty=0, where empty is the value before the clock edge.
REQ-023 An accepted push SHALL write {last_addr_in, data_size_in} at write_ptr and increment write_ptr.
REQ-024 An accepted pop SHALL increment read_ptr.
REQ-025 An accepted push and an accepted pop in the same cycle SHALL leave level unchanged; both pointers SHALL advance.
REQ-026 Output SHALL be first-word-fall-through: the head entry SHALL be presented combinationally from storage[read_ptr] with zero-cycle read latency.
REQ-027 The head entry SHALL appear on the outputs in the cycle after the push that makes the FIFO non-empty.
REQ-028 When empty=1, last_addr_out and data_size_out SHALL be forced to 0.
REQ-029 empty SHALL be 1 when level=0.
REQ-030 full SHALL be 1 when level=DEPTH.
REQ-031 almost_full SHALL be 1 when level>=AFULL_THR.
REQ-032 almost_empty SHALL be 1 when level<=AEMPTY_THR.
REQ-033 All status flags SHALL be derived from the registered level and SHALL reflect it in the same cycle.
REQ-034 If wr_en=1 while full=1, the push SHALL be dropped, storage SHALL be unchanged, and overflow SHALL be set, even if a pop is accepted in the same cycle.
REQ-035 If rd_en=1 while empty=1, the pop SHALL be ignored and underflow SHALL be set, even if a push is accepted in the same cycle.
REQ-036 high_water SHALL update to the next level whenever that level exceeds the current high_water.
REQ-037 clr_err=1 SHALL clear overflow and underflow and SHALL load high_water with the current level on the next edge.
REQ-038 A set condition in the same cycle as clr_err SHALL win over the clear.
REQ-039 Storage SHALL NOT be reset; its contents SHALL be observable only through REQ-026 while empty=0.

Reset
REQ-040 While rst_n=0, the block SHALL asynchronously clear both pointers, level, high_water, overflow and underflow.
REQ-041 While rst_n=0, outputs SHALL be: empty=1, full=0, almost_empty=1, almost_full=0, last_addr_out=0 and data_size_out=0.
REQ-042 wr_en and rd_en SHALL be ignored while rst_n=0.
REQ-043 Reset asserted mid-traffic SHALL discard all queued entries.
REQ-044 Operation SHALL resume on the first posedge after rst_n deasserts.

Verification
REQ-045 Bench SHALL cover fill: DEPTH=16, 16 pushes of addr=i, size=2i -> full=1, level=16, almost_full set from level 14; a 17th push sets overflow=1 and level stays 16.
REQ-046 Bench SHALL cover drain: 16 pops from full -> outputs sequence addr 0..15 in order, empty=1 after the last pop; one more pop sets underflow=1.
REQ-047 Bench SHALL cover wrap-around: 40 cycles of simultaneous push/pop with level=5 -> level stays 5, pointers wrap, data stays in order, no error flags.
REQ-048 Bench SHALL cover simultaneous access at boundaries: push+pop when empty -> level=1, underflow=1; push+pop when full -> level=15, overflow=1.
REQ-049 Bench SHALL cover error clearing: push 10, pop 4, then pulse clr_err -> high_water goes 10 -> 6 and overflow/underflow read 0.
REQ-050 Bench SHALL cover reset mid-operation: rst_n low at level=7 -> empty=1, level=0 and outputs 0 immediately, with no clock edge required.
